// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: RV64 funct3 encodings, FSM states, access sizes.
package lsu_pkg;

  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_INVALID = 3'b111;

  localparam int SIZE_B = 1;
  localparam int SIZE_H = 2;
  localparam int SIZE_W = 4;
  localparam int SIZE_D = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Index of the last byte of an access (N-1); doubles as the alignment mask.
  function automatic logic [2:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'(SIZE_B - 1);
      2'd1:    return 3'(SIZE_H - 1);
      2'd2:    return 3'(SIZE_W - 1);
      default: return 3'(SIZE_D - 1);
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: sign- or zero-extends the assembled little-endian bytes to XLEN.
// Purely combinational.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     raw,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [63:0] ext64;

  always_comb begin
    ext64 = raw;
    case (funct3)
      F3_LB:  ext64 = {{56{raw[7]}}, raw[7:0]};
      F3_LBU: ext64 = {56'b0, raw[7:0]};
      F3_LH:  ext64 = {{48{raw[15]}}, raw[15:0]};
      F3_LHU: ext64 = {48'b0, raw[15:0]};
      F3_LW:  ext64 = {{32{raw[31]}}, raw[31:0]};
      F3_LWU: ext64 = {32'b0, raw[31:0]};
      F3_LD:  ext64 = raw;
      default: ext64 = raw;
    endcase
  end

  generate
    if (XLEN <= 64) begin : g_narrow
      assign result = ext64[XLEN-1:0];
    end else begin : g_wide
      assign result = {{(XLEN-64){ext64[63] & ~funct3[2]}}, ext64};
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one memory byte per cycle, response N+1 cycles after handshake (faults: 1).
// req_ready only in IDLE; requests while busy are ignored. LSU_MISALIGN_EN allows misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [7:0]      mem_rdata
);

  lsu_state_e state_q, state_d;

  logic            write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      idx_q;
  logic [63:0]     raw_q;
  logic [63:0]     raw_next;
  logic [XLEN-1:0] ext_result;
  logic            req_fault;
  logic            misalign;
  logic            last_byte;

  // Zero padding lets a 64-bit store index bytes even when XLEN is narrower.
  logic [XLEN+63:0] wdata_wide;
  assign wdata_wide = {64'b0, wdata_q};

  assign misalign  = |(req_addr[2:0] & size_mask(req_funct3));
  assign last_byte = (idx_q == size_mask(funct3_q));

`ifdef LSU_MISALIGN_EN
  assign req_fault = (req_funct3 == F3_INVALID) || (req_write && req_funct3[2]);
`else
  assign req_fault = (req_funct3 == F3_INVALID) || (req_write && req_funct3[2]) || misalign;
`endif

  always_comb begin
    raw_next = raw_q;
    if (!write_q) begin
      raw_next[8*idx_q +: 8] = mem_rdata;
    end
  end

  // The final byte is folded in combinationally so the result is ready on entry to RESP.
  lsu_extend #(.XLEN(XLEN)) u_extend (
    .raw    (raw_next),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_fault ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_addr  = addr_q + XLEN'(idx_q);
        mem_we    = write_q;
        mem_re    = !write_q;
        mem_wdata = write_q ? wdata_wide[8*idx_q +: 8] : 8'h00;
        if (last_byte) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q   <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      raw_q     <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            idx_q    <= '0;
            raw_q    <= '0;
            if (req_fault) begin
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_XFER: begin
          raw_q <= raw_next;
          idx_q <= idx_q + 3'd1;
          if (last_byte) begin
            rsp_fault <= 1'b0;
            rsp_rdata <= write_q ? '0 : ext_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a 512-byte behavioural memory.
module tb_load_store_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [2:0]      req_funct3 = 3'b000;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic [XLEN-1:0] mem_addr;
  logic [7:0]      mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [7:0]      mem_rdata;

  load_store_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[8:0]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        fault;
    logic [63:0] rdata;
    int          n;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  task automatic run_req(input vec_t v, input string tag);
    int acc;
    int rsp_at;
    @(negedge clk);
    chk({tag, " ready_idle"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    // keep requesting with different fields: a busy unit must ignore them
    req_write  = ~v.wr;
    req_funct3 = 3'b011;
    req_addr   = v.addr + 64'd8;
    req_wdata  = ~v.wdata;
    acc = 0;
    rsp_at = 0;
    for (int c = 1; c <= 12 && rsp_at == 0; c++) begin
      @(negedge clk);
      if (mem_we || mem_re) begin
        chk($sformatf("%s addr%0d", tag, acc), mem_addr, v.addr + 64'(acc));
        chk($sformatf("%s dir%0d", tag, acc), 64'(mem_we), 64'(v.wr));
        if (v.wr && acc < 8) begin
          chk($sformatf("%s wbyte%0d", tag, acc), 64'(mem_wdata), 64'(v.wdata[8*acc +: 8]));
        end
        acc++;
      end
      if (rsp_valid) begin
        rsp_at = c;
        req_valid = 1'b0;
      end else begin
        chk($sformatf("%s busy_ready c%0d", tag, c), 64'(req_ready), 64'd0);
      end
    end
    req_valid = 1'b0;
    chk({tag, " latency"}, 64'(rsp_at), 64'(v.n + 1));
    chk({tag, " accesses"}, 64'(acc), 64'(v.n));
    chk({tag, " fault"}, 64'(rsp_fault), 64'(v.fault));
    chk({tag, " rdata"}, rsp_rdata, v.rdata);
    @(negedge clk);
    chk({tag, " ready_after"}, 64'(req_ready), 64'd1);
    chk({tag, " pulse_once"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rdata_hold"}, rsp_rdata, v.rdata);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    #1;
    mem[256] <= 8'h02;
    mem[300] <= 8'hF0;
    rst_n = 1'b0;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_re", 64'(mem_re), 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst rsp_rdata", rsp_rdata, 64'd0);
    chk("rst rsp_fault", 64'(rsp_fault), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //            wr    f3      addr     wdata                  fault rdata                  n
    vecs[0]  = '{1'b0, 3'b011, 64'd256, 64'h0,                 1'b0, 64'h2,                 8};
    vecs[1]  = '{1'b0, 3'b000, 64'd300, 64'h0,                 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 1};
    vecs[2]  = '{1'b0, 3'b100, 64'd300, 64'h0,                 1'b0, 64'hF0,                1};
    vecs[3]  = '{1'b1, 3'b011, 64'd264, 64'h1122334455667788,  1'b0, 64'h0,                 8};
    vecs[4]  = '{1'b0, 3'b011, 64'd264, 64'h0,                 1'b0, 64'h1122334455667788,  8};
`ifdef LSU_MISALIGN_EN
    vecs[5]  = '{1'b0, 3'b010, 64'd258, 64'h0,                 1'b0, 64'h0,                 4};
`else
    vecs[5]  = '{1'b0, 3'b010, 64'd258, 64'h0,                 1'b1, 64'h0,                 0};
`endif
    vecs[6]  = '{1'b0, 3'b111, 64'd256, 64'h0,                 1'b1, 64'h0,                 0};
    vecs[7]  = '{1'b1, 3'b100, 64'd256, 64'h55,                1'b1, 64'h0,                 0};
    vecs[8]  = '{1'b1, 3'b001, 64'd400, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h0,               2};
    vecs[9]  = '{1'b0, 3'b001, 64'd400, 64'h0,                 1'b0, 64'hFFFF_FFFF_FFFF_8001, 2};
    vecs[10] = '{1'b0, 3'b101, 64'd400, 64'h0,                 1'b0, 64'h8001,              2};
`ifdef LSU_MISALIGN_EN
    vecs[11] = '{1'b0, 3'b001, 64'd401, 64'h0,                 1'b0, 64'h80,                2};
`else
    vecs[11] = '{1'b0, 3'b001, 64'd401, 64'h0,                 1'b1, 64'h0,                 0};
`endif
    vecs[12] = '{1'b1, 3'b010, 64'd404, 64'h12345678DEADBEEF,  1'b0, 64'h0,                 4};
    vecs[13] = '{1'b0, 3'b010, 64'd404, 64'h0,                 1'b0, 64'hFFFF_FFFF_DEAD_BEEF, 4};
    vecs[14] = '{1'b0, 3'b110, 64'd404, 64'h0,                 1'b0, 64'hDEAD_BEEF,         4};
    vecs[15] = '{1'b1, 3'b000, 64'd405, 64'h5A,                1'b0, 64'h0,                 1};
    vecs[16] = '{1'b0, 3'b110, 64'd404, 64'h0,                 1'b0, 64'hDEAD_5AEF,         4};
    vecs[17] = '{1'b0, 3'b011, 64'd400, 64'h0,                 1'b0, 64'hDEAD_5AEF_0000_8001, 8};
`ifdef LSU_MISALIGN_EN
    vecs[18] = '{1'b1, 3'b011, 64'd260, 64'h0,                 1'b0, 64'h0,                 8};
`else
    vecs[18] = '{1'b1, 3'b011, 64'd260, 64'h0,                 1'b1, 64'h0,                 0};
`endif

    for (int i = 0; i < NVEC; i++) begin
      run_req(vecs[i], $sformatf("v%0d", i));
    end

    // store aborted by reset after three bytes
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b011;
    req_addr   = 64'd320;
    req_wdata  = 64'hA1A2A3A4A5A6A7A8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort we_inflight", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we", 64'(mem_we), 64'd0);
    chk("abort mem_addr", mem_addr, 64'd0);
    chk("abort req_ready", 64'(req_ready), 64'd1);
    chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("abort ready_in_reset", 64'(req_ready), 64'd1);
    chk("abort byte0", 64'(mem[320]), 64'hA8);
    chk("abort byte1", 64'(mem[321]), 64'hA7);
    chk("abort byte2", 64'(mem[322]), 64'hA6);
    chk("abort byte3", 64'(mem[323]), 64'h00);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_we || mem_re) seen++;
    end
    chk("abort quiet", 64'(seen), 64'd0);
    chk("abort rdata_cleared", rsp_rdata, 64'd0);
    run_req('{1'b0, 3'b011, 64'd320, 64'h0, 1'b0, 64'h0000_0000_00A6_A7A8, 8}, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
